// File: rtl/layer_tile_sequencer_pkg.sv
// Shared constants, FSM encoding and tile-count helpers for the layer tile sequencer.
package layer_tile_sequencer_pkg;
  localparam int OFM_RAM_SIZE = 2378675;
  localparam int ADDR_W       = $clog2(OFM_RAM_SIZE);
  localparam int WGT_ADDR_W   = 24;
  localparam int TILE_F       = 16;
  localparam int TILE_C       = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_ADV, S_DONE
  } state_t;

  // Number of 16-wide groups needed to cover n (ceil(n/16)).
  function automatic logic [7:0] ceil_div16(input logic [10:0] n);
    return {1'b0, n[10:4]} + {7'b0, |n[3:0]};
  endfunction

  // Size of the final group: the low nibble, or a full 16 when it is zero.
  function automatic logic [4:0] tail_cnt(input logic [3:0] lsb);
    return (lsb == 4'd0) ? 5'd16 : {1'b0, lsb};
  endfunction
endpackage

// File: rtl/layer_tile_sequencer_tile_loop_counter.sv
// Nested filter/channel group counters (channel inner) with registered per-tile counts and
// accumulator flags; outputs change only on init or step so they hold across a whole tile.
module layer_tile_sequencer_tile_loop_counter
  import layer_tile_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        step,
  input  logic [10:0] num_filter,
  input  logic [10:0] num_channel,
  output logic        f_last,
  output logic        c_last,
  output logic [4:0]  filt_cnt,
  output logic [4:0]  chan_cnt,
  output logic        acc_first,
  output logic        acc_last
);
  logic [6:0] f, c, f_nxt, c_nxt;
  logic [7:0] nfg, ncg;

  assign nfg    = ceil_div16(num_filter);
  assign ncg    = ceil_div16(num_channel);
  assign f_last = ({1'b0, f} == nfg - 8'd1);
  assign c_last = ({1'b0, c} == ncg - 8'd1);

  always_comb begin
    f_nxt = f;
    c_nxt = c;
    if (init) begin
      f_nxt = '0;
      c_nxt = '0;
    end else if (!c_last) begin
      c_nxt = c + 7'd1;
    end else if (!f_last) begin
      f_nxt = f + 7'd1;
      c_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f         <= '0;
      c         <= '0;
      filt_cnt  <= '0;
      chan_cnt  <= '0;
      acc_first <= 1'b0;
      acc_last  <= 1'b0;
    end else if (init || step) begin
      f         <= f_nxt;
      c         <= c_nxt;
      filt_cnt  <= ({1'b0, f_nxt} == nfg - 8'd1) ? tail_cnt(num_filter[3:0]) : 5'(TILE_F);
      chan_cnt  <= ({1'b0, c_nxt} == ncg - 8'd1) ? tail_cnt(num_channel[3:0]) : 5'(TILE_C);
      acc_first <= (c_nxt == 7'd0);
      acc_last  <= ({1'b0, c_nxt} == ncg - 8'd1);
    end
  end
endmodule

// File: rtl/layer_tile_sequencer.sv
// Splits one layer into TILE_F x TILE_C tiles, issuing a start pulse with base addresses per tile
// and returning done_layer after the last tile_done. Strides are multiplied once in LOAD; walking is adds.
module layer_tile_sequencer
  import layer_tile_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_layer,
  input  logic [8:0]            ifm_size,
  input  logic [10:0]           ifm_channel,
  input  logic [1:0]            kernel_size,
  input  logic [10:0]           num_filter,
  input  logic                  maxpool_mode,
  input  logic [1:0]            maxpool_stride,
  input  logic                  upsample_mode,
  input  logic [ADDR_W-1:0]     start_read_addr,
  input  logic [ADDR_W-1:0]     start_write_addr,
  input  logic                  tile_done,
  output logic                  tile_start,
  output logic [ADDR_W-1:0]     ifm_addr,
  output logic [ADDR_W-1:0]     ofm_addr,
  output logic [WGT_ADDR_W-1:0] wgt_addr,
  output logic [4:0]            filt_cnt,
  output logic [4:0]            chan_cnt,
  output logic                  acc_first,
  output logic                  acc_last,
  output logic                  busy,
  output logic                  done_layer
);
  state_t                state;
  logic [8:0]            cfg_ifm_size;
  logic [10:0]           cfg_channel, cfg_filter;
  logic [1:0]            cfg_kernel, cfg_mp_stride;
  logic                  cfg_mp, cfg_up;
  logic [ADDR_W-1:0]     cfg_rd, cfg_wr;
  logic [ADDR_W-1:0]     ifm_gstride, ofm_gstride;
  logic [WGT_ADDR_W-1:0] wgt_tstride;
  logic [9:0]            ofm_dim;
  logic [17:0]           ifm_sq;
  logic [19:0]           ofm_sq;
  logic                  empty_layer, cnt_init, cnt_step, f_last, c_last;

  assign ofm_dim     = cfg_up ? {cfg_ifm_size, 1'b0}
                     : (cfg_mp && cfg_mp_stride == 2'd2) ? {2'b0, cfg_ifm_size[8:1]}
                     : {1'b0, cfg_ifm_size};
  assign ifm_sq      = cfg_ifm_size * cfg_ifm_size;
  assign ofm_sq      = ofm_dim * ofm_dim;
  assign empty_layer = (cfg_filter == 11'd0) || (cfg_channel == 11'd0);
  assign cnt_init    = (state == S_LOAD) && !empty_layer;
  assign cnt_step    = (state == S_ADV);

  layer_tile_sequencer_tile_loop_counter u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .init       (cnt_init),
    .step       (cnt_step),
    .num_filter (cfg_filter),
    .num_channel(cfg_channel),
    .f_last     (f_last),
    .c_last     (c_last),
    .filt_cnt   (filt_cnt),
    .chan_cnt   (chan_cnt),
    .acc_first  (acc_first),
    .acc_last   (acc_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cfg_ifm_size  <= '0;
      cfg_channel   <= '0;
      cfg_filter    <= '0;
      cfg_kernel    <= '0;
      cfg_mp_stride <= '0;
      cfg_mp        <= 1'b0;
      cfg_up        <= 1'b0;
      cfg_rd        <= '0;
      cfg_wr        <= '0;
      ifm_gstride   <= '0;
      ofm_gstride   <= '0;
      wgt_tstride   <= '0;
      ifm_addr      <= '0;
      ofm_addr      <= '0;
      wgt_addr      <= '0;
      tile_start    <= 1'b0;
      busy          <= 1'b0;
      done_layer    <= 1'b0;
    end else begin
      tile_start <= 1'b0;
      done_layer <= 1'b0;
      case (state)
        S_IDLE: if (start_layer) begin
          cfg_ifm_size  <= ifm_size;
          cfg_channel   <= ifm_channel;
          cfg_filter    <= num_filter;
          cfg_kernel    <= kernel_size;
          cfg_mp_stride <= maxpool_stride;
          cfg_mp        <= maxpool_mode;
          cfg_up        <= upsample_mode;
          cfg_rd        <= start_read_addr;
          cfg_wr        <= start_write_addr;
          busy          <= 1'b1;
          state         <= S_LOAD;
        end
        S_LOAD: begin
          ifm_gstride <= ADDR_W'(ifm_sq * TILE_C);
          ofm_gstride <= ADDR_W'(ofm_sq * TILE_F);
          wgt_tstride <= (cfg_kernel == 2'd3) ? WGT_ADDR_W'(TILE_F * TILE_C * 9)
                                              : WGT_ADDR_W'(TILE_F * TILE_C);
          if (empty_layer) begin
            done_layer <= 1'b1;
            state      <= S_DONE;
          end else begin
            ifm_addr   <= cfg_rd;
            ofm_addr   <= cfg_wr;
            wgt_addr   <= '0;
            tile_start <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT:  if (tile_done) state <= S_ADV;
        S_ADV: begin
          wgt_addr <= wgt_addr + wgt_tstride;
          if (!c_last) begin
            ifm_addr   <= ifm_addr + ifm_gstride;
            tile_start <= 1'b1;
            state      <= S_ISSUE;
          end else if (!f_last) begin
            ifm_addr   <= cfg_rd;
            ofm_addr   <= ofm_addr + ofm_gstride;
            tile_start <= 1'b1;
            state      <= S_ISSUE;
          end else begin
            done_layer <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_layer_tile_sequencer.sv
// Directed table of layer configurations with hand-computed group counts and strides, plus
// hand-written sequences for reset, protocol misuse and asynchronous abort.
module tb_layer_tile_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_layer = 1'b0;
  logic [8:0]  ifm_size = '0;
  logic [10:0] ifm_channel = '0;
  logic [1:0]  kernel_size = '0;
  logic [10:0] num_filter = '0;
  logic        maxpool_mode = 1'b0;
  logic [1:0]  maxpool_stride = '0;
  logic        upsample_mode = 1'b0;
  logic [21:0] start_read_addr = '0;
  logic [21:0] start_write_addr = '0;
  logic        tile_done = 1'b0;
  logic        tile_start;
  logic [21:0] ifm_addr, ofm_addr;
  logic [23:0] wgt_addr;
  logic [4:0]  filt_cnt, chan_cnt;
  logic        acc_first, acc_last, busy, done_layer;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  layer_tile_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start_layer(start_layer), .ifm_size(ifm_size),
    .ifm_channel(ifm_channel), .kernel_size(kernel_size), .num_filter(num_filter),
    .maxpool_mode(maxpool_mode), .maxpool_stride(maxpool_stride), .upsample_mode(upsample_mode),
    .start_read_addr(start_read_addr), .start_write_addr(start_write_addr), .tile_done(tile_done),
    .tile_start(tile_start), .ifm_addr(ifm_addr), .ofm_addr(ofm_addr), .wgt_addr(wgt_addr),
    .filt_cnt(filt_cnt), .chan_cnt(chan_cnt), .acc_first(acc_first), .acc_last(acc_last),
    .busy(busy), .done_layer(done_layer)
  );

  typedef struct {
    int ifm, ch, k, nf, mp, mps, up, rd, wr;  // stimulus
    int nfg, ncg, ifm_st, ofm_st, wgt_st;     // hand-computed expectations
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({tile_start, ifm_addr, ofm_addr, wgt_addr, filt_cnt, chan_cnt,
                 acc_first, acc_last, busy, done_layer});
  endfunction

  task automatic drive_cfg(input vec_t v);
    ifm_size         = 9'(v.ifm);
    ifm_channel      = 11'(v.ch);
    kernel_size      = 2'(v.k);
    num_filter       = 11'(v.nf);
    maxpool_mode     = 1'(v.mp);
    maxpool_stride   = 2'(v.mps);
    upsample_mode    = 1'(v.up);
    start_read_addr  = 22'(v.rd);
    start_write_addr = 22'(v.wr);
  endtask

  // Runs one layer, answering every tile with tile_done and checking each tile's fields.
  task automatic run_layer(input vec_t v, input string tag, input bit poke);
    int f, c, tiles, since, guard;
    bit fin;
    logic [79:0] exp_t;
    @(negedge clk);
    drive_cfg(v);
    start_layer = 1'b1;
    @(negedge clk);
    start_layer = 1'b0;
    since = 1;
    check({tag, " busy in LOAD"}, 128'(busy), 128'(1));
    f = 0; c = 0; tiles = 0; guard = 0; fin = 1'b0;
    while (!fin && guard < 20000) begin
      @(negedge clk);
      since++;
      guard++;
      if (tile_start) begin
        if (tiles == 0 || poke) check({tag, " tile_start latency"}, 128'(since), 128'(2));
        exp_t = {22'(v.rd + c * v.ifm_st), 22'(v.wr + f * v.ofm_st),
                 24'((f * v.ncg + c) * v.wgt_st),
                 5'((f == v.nfg - 1) ? v.nf - 16 * f : 16),
                 5'((c == v.ncg - 1) ? v.ch - 16 * c : 16),
                 (c == 0), (c == v.ncg - 1)};
        check($sformatf("%s tile f%0d c%0d", tag, f, c),
              128'({ifm_addr, ofm_addr, wgt_addr, filt_cnt, chan_cnt, acc_first, acc_last}),
              128'(exp_t));
        tiles++;
        c++;
        if (c == v.ncg) begin c = 0; f++; end
        @(negedge clk);
        if (poke) begin
          start_layer = 1'b1;
          num_filter  = 11'd0;
          @(negedge clk);
          start_layer = 1'b0;
        end
        tile_done = 1'b1;
        since = 0;
        @(negedge clk);
        tile_done = 1'b0;
        since = 1;
      end else if (done_layer) begin
        check({tag, " done latency"}, 128'(since), 128'(2));
        check({tag, " tile count"}, 128'(tiles), 128'(v.nfg * v.ncg));
        @(negedge clk);
        check({tag, " done pulse width / busy drop"}, 128'({done_layer, busy}), 128'(0));
        fin = 1'b1;
      end
    end
    if (!fin) check({tag, " completion within budget"}, 128'(0), 128'(1));
  endtask

  initial begin
    //         ifm ch   k  nf   mp mps up rd       wr       nfg ncg ifm_st ofm_st wgt_st
    tbl[0] = '{54, 16,  3, 16,  1, 2,  0, 0,       0,       1,  1,  46656, 11664, 2304};
    tbl[1] = '{13, 512, 3, 1024,0, 1,  0, 1341184, 1427712, 64, 32, 2704,  2704,  2304};
    tbl[2] = '{13, 512, 1, 255, 0, 1,  0, 0,       0,       16, 32, 2704,  2704,  256};
    tbl[3] = '{13, 256, 1, 128, 0, 1,  1, 0,       1773655, 8,  16, 2704,  10816, 256};
    tbl[4] = '{13, 16,  3, 0,   0, 1,  0, 0,       0,       0,  0,  0,     0,     0};
    tbl[5] = '{13, 0,   1, 16,  0, 1,  0, 0,       0,       0,  0,  0,     0,     0};
    tbl[6] = '{13, 48,  1, 20,  1, 1,  0, 4194000, 4190000, 2,  3,  2704,  2704,  256};
    tbl[7] = '{27, 20,  3, 17,  1, 2,  0, 100,     200,     2,  2,  11664, 2704,  2304};

    #1;
    check("reset outputs", all_outs(), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("outputs after reset release", all_outs(), 128'(0));

    // Spurious tile_done while idle must not start anything.
    @(negedge clk);
    tile_done = 1'b1;
    @(negedge clk);
    tile_done = 1'b0;
    repeat (3) @(negedge clk);
    check("idle after spurious tile_done", 128'({tile_start, busy, done_layer}), 128'(0));

    for (int i = 0; i < 8; i++) run_layer(tbl[i], $sformatf("vec%0d", i), 1'b0);

    // start_layer pulsed in WAIT (with num_filter 0 on the bus) must be ignored.
    run_layer(tbl[7], "start-in-WAIT", 1'b1);

    // Asynchronous reset while waiting on a tile.
    @(negedge clk);
    drive_cfg(tbl[0]);
    start_layer = 1'b1;
    @(negedge clk);
    start_layer = 1'b0;
    @(negedge clk);
    check("pre-abort tile_start", 128'({tile_start, busy}), 128'(2'b11));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async reset outputs", all_outs(), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (4) begin
        @(negedge clk);
        if (done_layer || tile_start || busy) seen++;
      end
      check("no activity after abort", 128'(seen), 128'(0));
    end
    run_layer(tbl[0], "post-reset", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/layer_tile_sequencer.md
Name: layer_tile_sequencer

Overview:
Per-layer sequencer directly downstream of the network-level layer controller. Consumes the layer configuration plus the start_layer pulse, and splits the layer into systolic-array tiles of TILE_F filters x TILE_C channels. For each tile it issues a start pulse with base addresses to the datapath and waits for tile completion. Returns a one-cycle done_layer pulse to the layer controller when the layer is finished.

Parameters:
OFM_RAM_SIZE, 2378675, feature-map RAM depth; ADDR_W = $clog2(OFM_RAM_SIZE) = 22
WGT_ADDR_W, 24, weight-memory address width
TILE_F, 16, filters per tile (array rows)
TILE_C, 16, channels per tile (array columns)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_layer  in  1  one-cycle pulse; samples the config inputs
ifm_size  in  9  input feature-map width/height
ifm_channel  in  11  input channel count
kernel_size  in  2  1 or 3
num_filter  in  11  filter count
maxpool_mode  in  1  maxpool enabled
maxpool_stride  in  2  1 or 2
upsample_mode  in  1  2x upsample
start_read_addr  in  ADDR_W  IFM base address
start_write_addr  in  ADDR_W  OFM base address
tile_done  in  1  datapath finished the current tile (pulse)
tile_start  out  1  one-cycle pulse per tile
ifm_addr  out  ADDR_W  IFM base address of the tile
ofm_addr  out  ADDR_W  OFM base address of the tile
wgt_addr  out  WGT_ADDR_W  weight base address of the tile
filt_cnt  out  5  valid filters in the tile (1..TILE_F)
chan_cnt  out  5  valid channels in the tile (1..TILE_C)
acc_first  out  1  tile is channel group 0 (clear accumulators)
acc_last  out  1  tile is the last channel group (write OFM)
busy  out  1  high from LOAD through DONE
done_layer  out  1  one-cycle pulse at layer end

Behaviour:
- Reset: every output is 0, the FSM is IDLE, all counters and registers are 0. Reset mid-layer aborts immediately; no done_layer is issued.
- FSM states: IDLE, LOAD, ISSUE, WAIT, ADV, DONE.
- IDLE: when start_layer=1, register all config inputs and go to LOAD. start_layer is ignored in every other state.
- LOAD (1 cycle) computes:
  - ofm_dim = upsample_mode ? 2*ifm_size : (maxpool_mode && maxpool_stride==2) ? ifm_size>>1 : ifm_size
  - ifm_gstride = TILE_C*ifm_size^2
  - ofm_gstride = TILE_F*ofm_dim^2
  - wgt_tstride = TILE_F*TILE_C*k*k (k*k = 1 or 9)
  - nfg = ceil(num_filter/TILE_F); ncg = ceil(ifm_channel/TILE_C)
  - If num_filter==0 or ifm_channel==0, go to DONE; otherwise set f=0, c=0, ifm_addr=start_read_addr, ofm_addr=start_write_addr, wgt_addr=0, and go to ISSUE.
- ISSUE (1 cycle): tile_start=1. filt_cnt, chan_cnt, acc_first=(c==0) and acc_last=(c==ncg-1) are valid and held stable until the next ISSUE. Go to WAIT.
- WAIT: hold until tile_done=1, then go to ADV. tile_done is ignored outside WAIT.
- ADV (channel loop is inner):
  - wgt_addr += wgt_tstride.
  - If c<ncg-1: c++, ifm_addr += ifm_gstride, go to ISSUE.
  - Else if f<nfg-1: f++, c=0, ifm_addr=start_read_addr, ofm_addr += ofm_gstride, go to ISSUE.
  - Else go to DONE.
- DONE (1 cycle): done_layer=1, busy=0 next cycle, go to IDLE.
- filt_cnt = last filter group ? num_filter - f*TILE_F : TILE_F. chan_cnt is computed the same way from ifm_channel.
- Timing: start_layer at cycle T gives tile_start at T+2. tile_done at cycle D gives the next tile_start at D+2, or done_layer at D+2 after the final tile.
- Arithmetic: multiplies occur only in LOAD; all other address updates are adds. Addresses wrap modulo 2^ADDR_W (2^WGT_ADDR_W for wgt_addr) with no saturation.

Decomposition:
- Shared package: TILE_F and TILE_C, the state encoding, ADDR_W derivation, and a ceil-divide-by-16 function.
- One natural sub-module: tile_loop_counter (nested f/c counters, first/last flags, partial-count generation).

Test Plan:
1. Single tile: ifm_size 54, ch 16, k3, nf 16, maxpool stride 2, read 0, write 0 -> one tile_start at T+2 with ifm_addr 0, ofm_addr 0, acc_first=acc_last=1, filt_cnt=chan_cnt=16; done_layer at D+2 for exactly one cycle.
2. Large layer: ifm 13, ch 512, nf 1024, k3, read 1341184, write 1427712 -> 2048 tile_starts.
   - Tile 2: ifm_addr 1343888, wgt_addr 2304.
   - Tile 33: ofm_addr 1430416, ifm_addr 1341184, acc_first=1.
3. Partial filter group: ifm 13, ch 512, nf 255, k1 -> 16x32 tiles; last group filt_cnt=15; wgt stride 256.
4. Upsample: ifm 13, ch 256, nf 128, k1, upsample, write 1773655 -> filter group 1 ofm_addr 1784471 (stride 10816).
5. Edge and protocol cases:
   - num_filter 0 -> done_layer at T+2 with no tile_start.
   - start_layer pulsed during WAIT -> ignored.
   - Spurious tile_done in IDLE -> no effect.
6. Reset asserted in WAIT -> all outputs 0 asynchronously; a new start_layer then behaves exactly as in scenario 1.
